// File: rtl/ysyx_041461_exe_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_041461_exe_div_pkg                                    |
// | Brief   : State encodings, iteration counts and operand helpers for  |
// |           the EXE-stage RV64M divider.                               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package ysyx_041461_exe_div_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  localparam int         CNT_W       = 7;
  localparam logic [6:0] DIV_ITER_64 = 7'd64;
  localparam logic [6:0] DIV_ITER_32 = 7'd32;

  localparam logic [63:0] MIN_NEG_64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN_NEG_32 = 64'hFFFF_FFFF_8000_0000;

  // Word ops see only the low 32 bits, widened according to signedness.
  function automatic logic [63:0] ext_operand(input logic [63:0] v,
                                              input logic        word,
                                              input logic        sgn);
    if (!word)
      return v;
    return sgn ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  function automatic logic [63:0] sext_word(input logic [63:0] v,
                                            input logic        word);
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_041461_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_041461_div_step                                       |
// | Brief   : One restoring-division step: shift the remainder/quotient  |
// |           pair left by one and trial-subtract the divisor.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ysyx_041461_div_step (
  input  logic [127:0] i_pair,
  input  logic [63:0]  i_divisor,
  output logic [127:0] o_pair
);

  // The bit shifted out of the pair still belongs to the partial remainder,
  // so the comparison is done on 65 bits.
  logic [64:0] w_top;
  logic        w_ge;
  logic [63:0] w_diff;

  assign w_top  = i_pair[127:63];
  assign w_ge   = (w_top >= {1'b0, i_divisor});
  assign w_diff = w_top[63:0] - i_divisor;

  always_comb begin
    o_pair = {i_pair[126:0], 1'b0};
    if (w_ge) begin
      o_pair[127:64] = w_diff;
      o_pair[0]      = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_041461_exe_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ysyx_041461_exe_div                                        |
// | Brief   : Iterative radix-2 restoring divider for RV64M DIV/REM ops, |
// |           stalling ID/EXE until the result is taken by EXE/MEM.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ysyx_041461_exe_div
  import ysyx_041461_exe_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid_in,
  input  logic        div_signed,
  input  logic        div_rem,
  input  logic        div_word,
  input  logic [63:0] div_dividend,
  input  logic [63:0] div_divisor,
  input  logic        div_flush,
  input  logic        div_result_ready,
  output logic        div_busy,
  output logic        div_done,
  output logic [63:0] div_result
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic             r_signed;
  logic             r_rem;
  logic             r_word;
  logic [63:0]      r_dividend;
  logic [63:0]      r_divisor;
  logic [127:0]     r_pair;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [63:0]      r_result;
  logic             r_done;

  logic [63:0]  w_dvd_ext;
  logic [63:0]  w_dsr_ext;
  logic         w_div_zero;
  logic         w_overflow;
  logic         w_special;
  logic [63:0]  w_special_val;
  logic [63:0]  w_abs_dvd;
  logic [63:0]  w_abs_dsr;
  logic [127:0] w_step_pair;
  logic [63:0]  w_quot;
  logic [63:0]  w_remd;
  logic [63:0]  w_fix_val;

  assign w_dvd_ext = ext_operand(div_dividend, div_word, div_signed);
  assign w_dsr_ext = ext_operand(div_divisor,  div_word, div_signed);

  // Special cases are evaluated on the extended operands held during PREP.
  assign w_div_zero = (r_divisor == 64'd0);
  assign w_overflow = r_signed && (r_divisor == {64{1'b1}}) &&
                      (r_dividend == (r_word ? MIN_NEG_32 : MIN_NEG_64));
  assign w_special  = w_div_zero || w_overflow;

  always_comb begin
    w_special_val = r_rem ? 64'd0 : r_dividend;
    if (w_div_zero)
      w_special_val = r_rem ? r_dividend : {64{1'b1}};
  end

  assign w_abs_dvd = (r_signed && r_dividend[63]) ? -r_dividend : r_dividend;
  assign w_abs_dsr = (r_signed && r_divisor[63])  ? -r_divisor  : r_divisor;

  ysyx_041461_div_step u_step (
    .i_pair    (r_pair),
    .i_divisor (r_divisor),
    .o_pair    (w_step_pair)
  );

  assign w_quot    = r_q_neg ? -r_pair[63:0]   : r_pair[63:0];
  assign w_remd    = r_r_neg ? -r_pair[127:64] : r_pair[127:64];
  assign w_fix_val = sext_word(r_rem ? w_remd : w_quot, r_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= DIV_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (div_flush) begin
      w_state_nxt = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: if (div_valid_in)     w_state_nxt = DIV_PREP;
        DIV_PREP: w_state_nxt = w_special ? DIV_DONE : DIV_CALC;
        DIV_CALC: if (r_cnt == 7'd1)    w_state_nxt = DIV_FIX;
        DIV_FIX:  w_state_nxt = DIV_DONE;
        DIV_DONE: if (div_result_ready) w_state_nxt = DIV_IDLE;
        default:  w_state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_signed   <= 1'b0;
      r_rem      <= 1'b0;
      r_word     <= 1'b0;
      r_dividend <= 64'd0;
      r_divisor  <= 64'd0;
      r_pair     <= 128'd0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_result   <= 64'd0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == DIV_DONE);
      if (!div_flush) begin
        case (r_state)
          DIV_IDLE: begin
            if (div_valid_in) begin
              r_signed   <= div_signed;
              r_rem      <= div_rem;
              r_word     <= div_word;
              r_dividend <= w_dvd_ext;
              r_divisor  <= w_dsr_ext;
            end
          end
          DIV_PREP: begin
            if (w_special) begin
              r_result <= sext_word(w_special_val, r_word);
            end else begin
              // Word dividends are pre-aligned so 32 steps leave the
              // quotient in the low word and the remainder in the high half.
              r_pair    <= r_word ? {64'd0, w_abs_dvd[31:0], 32'd0}
                                  : {64'd0, w_abs_dvd};
              r_divisor <= w_abs_dsr;
              r_q_neg   <= r_signed && (r_dividend[63] ^ r_divisor[63]);
              r_r_neg   <= r_signed && r_dividend[63];
              r_cnt     <= r_word ? DIV_ITER_32 : DIV_ITER_64;
            end
          end
          DIV_CALC: begin
            r_pair <= w_step_pair;
            r_cnt  <= r_cnt - 7'd1;
          end
          DIV_FIX: begin
            r_result <= w_fix_val;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign div_busy   = rst && !div_flush &&
                      ((r_state != DIV_IDLE) || div_valid_in) &&
                      !((r_state == DIV_DONE) && div_result_ready);
  assign div_done   = r_done;
  assign div_result = r_result;

endmodule
`default_nettype wire
